// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave backed by an on-chip word memory.
//   aclk, areset         clock (rising edge) and asynchronous active-high reset
//   aw*  / awready       write request (id, addr, len, size, burst)
//   w*   / wready        write data beats with byte strobes
//   b*   / bready        write response (bid echoes awid)
//   ar*  / arready       read request (id, addr, len, size, burst)
//   r*   / rready        read data beats, full aligned word per beat
// Write and read paths are independent FSMs, one outstanding burst each.
// Out-of-range words, oversize beats, reserved burst type and illegal WRAP
// lengths answer SLVERR. Memory contents survive reset.
module axi4_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // Address of the following beat. The reserved burst type falls through to INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [7:0] len,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
    logic [ADDR_W-1:0] step, incr, span, lower;
    step  = ADDR_W'(1) << size;
    incr  = (addr & ~(step - ADDR_W'(1))) + step;
    span  = (ADDR_W'(len) + ADDR_W'(1)) << size;
    lower = addr & ~(span - ADDR_W'(1));
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP && incr == lower + span)
      next_addr = lower;
    else
      next_addr = incr;
  endfunction

  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
    return (addr >> LSB) >= ADDR_W'(MEM_WORDS);
  endfunction

  // Errors that poison every beat of a burst.
  function automatic logic burst_err(input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
    logic legal_wrap_len;
    legal_wrap_len = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (int'(size) > LSB) || (burst == BURST_RSVD) ||
           (burst == BURST_WRAP && !legal_wrap_len);
  endfunction

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t          w_state_reg;
  logic [ID_W-1:0]   w_id_reg;
  logic [ADDR_W-1:0] w_addr_reg;
  logic [7:0]        w_len_reg, w_cnt_reg;
  logic [2:0]        w_size_reg;
  logic [1:0]        w_burst_reg;
  logic              w_err_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;

  logic              w_beat, w_is_last, w_oob, w_beat_err, mem_we;
  logic [IDX_W-1:0]  mem_wr_idx;

  // Gated by areset so the handshake is open on the very first edge after release.
  assign awready    = (w_state_reg == W_IDLE) && !areset;
  assign wready     = (w_state_reg == W_DATA);
  assign w_beat     = wvalid && wready;
  assign w_is_last  = (w_cnt_reg == w_len_reg);
  assign w_oob      = addr_oob(w_addr_reg);
  assign w_beat_err = w_oob || (wlast != w_is_last);
  assign mem_we     = w_beat && !w_oob;
  assign mem_wr_idx = w_addr_reg[LSB +: IDX_W];
  assign bvalid     = bvalid_reg;
  assign bresp      = bresp_reg;
  assign bid        = w_id_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_size_reg  <= '0;
      w_burst_reg <= '0;
      w_err_reg   <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: if (awvalid) begin
          w_id_reg    <= awid;
          w_addr_reg  <= awaddr;
          w_len_reg   <= awlen;
          w_size_reg  <= awsize;
          w_burst_reg <= awburst;
          w_cnt_reg   <= '0;
          w_err_reg   <= burst_err(awlen, awsize, awburst);
          w_state_reg <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_size_reg, w_burst_reg);
          w_cnt_reg  <= w_cnt_reg + 8'd1;
          w_err_reg  <= w_err_reg || w_beat_err;
          // The burst length alone decides the end; a wrong wlast only flags an error.
          if (w_is_last) begin
            bvalid_reg  <= 1'b1;
            bresp_reg   <= (w_err_reg || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            w_state_reg <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_reg  <= 1'b0;
          w_state_reg <= W_IDLE;
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t          r_state_reg;
  logic [ID_W-1:0]   r_id_reg;
  logic [ADDR_W-1:0] r_addr_reg;
  logic [7:0]        r_len_reg, r_cnt_reg;
  logic [2:0]        r_size_reg;
  logic [1:0]        r_burst_reg;
  logic              r_burst_err_reg;
  logic              rvalid_reg, rlast_reg, r_oob_reg;
  logic [1:0]        rresp_reg;

  logic              ar_hs, r_advance, rd_fetch, rd_fetch_oob;
  logic [ADDR_W-1:0] r_next_addr, rd_fetch_addr;
  logic [IDX_W-1:0]  rd_fetch_idx;
  logic [DATA_W-1:0] rd_word;

  assign arready       = (r_state_reg == R_IDLE) && !areset;
  assign ar_hs         = arvalid && arready;
  assign r_advance     = rvalid_reg && rready && !rlast_reg;
  assign r_next_addr   = next_addr(r_addr_reg, r_len_reg, r_size_reg, r_burst_reg);
  // One memory fetch per presented beat: beat 0 at AR, the rest on acceptance.
  assign rd_fetch      = ar_hs || r_advance;
  assign rd_fetch_addr = (r_state_reg == R_IDLE) ? araddr : r_next_addr;
  assign rd_fetch_oob  = addr_oob(rd_fetch_addr);
  assign rd_fetch_idx  = rd_fetch_addr[LSB +: IDX_W];

  assign rvalid = rvalid_reg;
  assign rlast  = rlast_reg;
  assign rresp  = rresp_reg;
  assign rid    = r_id_reg;
  // The fetch register only moves on rd_fetch, so data holds through a stall.
  assign rdata  = (rvalid_reg && !r_oob_reg) ? rd_word : '0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_reg     <= R_IDLE;
      r_id_reg        <= '0;
      r_addr_reg      <= '0;
      r_len_reg       <= '0;
      r_cnt_reg       <= '0;
      r_size_reg      <= '0;
      r_burst_reg     <= '0;
      r_burst_err_reg <= 1'b0;
      rvalid_reg      <= 1'b0;
      rlast_reg       <= 1'b0;
      r_oob_reg       <= 1'b0;
      rresp_reg       <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: if (arvalid) begin
          r_id_reg        <= arid;
          r_addr_reg      <= araddr;
          r_len_reg       <= arlen;
          r_size_reg      <= arsize;
          r_burst_reg     <= arburst;
          r_cnt_reg       <= '0;
          r_burst_err_reg <= burst_err(arlen, arsize, arburst);
          rvalid_reg      <= 1'b1;
          rlast_reg       <= (arlen == 8'd0);
          r_oob_reg       <= rd_fetch_oob;
          rresp_reg       <= (burst_err(arlen, arsize, arburst) || rd_fetch_oob) ?
                             RESP_SLVERR : RESP_OKAY;
          r_state_reg     <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast_reg) begin
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            r_state_reg <= R_IDLE;
          end else begin
            r_addr_reg <= r_next_addr;
            r_cnt_reg  <= r_cnt_reg + 8'd1;
            rlast_reg  <= (r_cnt_reg + 8'd1 == r_len_reg);
            r_oob_reg  <= rd_fetch_oob;
            rresp_reg  <= (r_burst_err_reg || rd_fetch_oob) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // ---------------- memory: one byte-wide array per lane ----------------
  // A read and write to the same word on one edge returns the old contents.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] mem [MEM_WORDS];
      logic [7:0] rd_byte_reg;
      always_ff @(posedge aclk) begin
        if (mem_we && wstrb[gi])
          mem[mem_wr_idx] <= wdata[gi*8 +: 8];
        if (rd_fetch)
          rd_byte_reg <= mem[rd_fetch_idx];
      end
      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axi4_slave_mem.sv
module tb_axi4_slave_mem;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi4_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [63:0] model [int unsigned];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          r_pop_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address sequence written straight from the burst rules, using division.
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    int unsigned step, bnd, lo, n;
    step = 32'd1 << size;
    if (burst == 2'b00) return a;
    n = (a / step) * step + step;
    if (burst == 2'b10) begin
      bnd = (int'(len) + 1) * step;
      lo  = (a / bnd) * bnd;
      if (n == lo + bnd) n = lo;
    end
    return n;
  endfunction

  function automatic logic oob(input logic [31:0] a);
    return (a >> 3) >= 32'd1024;
  endfunction

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size > 3'd3) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Scoreboard side: responses are compared as the DUT hands them over.
  always @(negedge aclk) begin
    if (bvalid && bready) begin
      if (b_q.size() == 0) check("b_unexpected", 64'(bvalid), 64'd0);
      else begin
        b_exp_t e;
        e = b_q.pop_front();
        check("bid", 64'(bid), 64'(e.id));
        check("bresp", 64'(bresp), 64'(e.resp));
        $display("B  id=%0h resp=%0d", bid, bresp);
      end
    end
    if (rvalid && rready) begin
      if (r_q.size() == 0) check("r_unexpected", 64'(rvalid), 64'd0);
      else begin
        r_exp_t e;
        e = r_q.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", 64'(rresp), 64'(e.resp));
        check("rid", 64'(rid), 64'(e.id));
        check("rlast", 64'(rlast), 64'(e.last));
        $display("R  id=%0h data=%016h resp=%0d last=%0d", rid, rdata, rresp, rlast);
      end
      r_pop_cnt++;
    end
  end

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int early_last);
    logic [31:0] a;
    logic        err;
    b_exp_t      e;
    int          t;
    err = burst_bad(len, size, burst);
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      logic exp_last;
      exp_last = (early_last >= 0) ? (b == early_last) : (b == int'(len));
      if (exp_last != (b == int'(len))) err = 1'b1;
      if (oob(a)) err = 1'b1;
      else for (int k = 0; k < 8; k++)
        if (ws[b][k]) model[a >> 3][k*8 +: 8] = wd[b][k*8 +: 8];
      a = nxt(a, len, size, burst);
    end
    e.id = id;
    e.resp = err ? 2'b10 : 2'b00;
    b_q.push_back(e);
    @(posedge aclk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    check("aw_accept", 64'(awready), 64'd1);
    @(posedge aclk); #1 awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wd[b]; wstrb = ws[b]; wvalid = 1'b1;
      wlast = (early_last >= 0) ? (b == early_last) : (b == int'(len));
      t = 0;
      @(negedge aclk);
      while (!wready && t < 50) begin @(negedge aclk); t++; end
      check("w_accept", 64'(wready), 64'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (b_q.size() != 0 && t < 50) begin @(posedge aclk); t++; end
    check("b_done", 64'(b_q.size()), 64'd0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_after);
    logic [31:0] a;
    logic        berr;
    r_exp_t      e;
    int          t, base;
    logic [63:0] s_data;
    logic [1:0]  s_resp;
    logic        s_last;
    logic [3:0]  s_id;
    berr = burst_bad(len, size, burst);
    a = addr;
    base = r_pop_cnt;
    for (int b = 0; b <= int'(len); b++) begin
      e.id = id;
      e.last = (b == int'(len));
      if (oob(a)) begin e.data = 64'd0; e.resp = 2'b10; end
      else begin e.data = model[a >> 3]; e.resp = berr ? 2'b10 : 2'b00; end
      r_q.push_back(e);
      a = nxt(a, len, size, burst);
    end
    @(posedge aclk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    check("ar_accept", 64'(arready), 64'd1);
    @(posedge aclk); #1 arvalid = 1'b0;
    if (stall_after >= 0) begin
      t = 0;
      while (r_pop_cnt < base + stall_after + 1 && t < 50) begin @(posedge aclk); t++; end
      #1 rready = 1'b0;
      @(negedge aclk);
      check("stall_rvalid", 64'(rvalid), 64'd1);
      s_data = rdata; s_resp = rresp; s_last = rlast; s_id = rid;
      repeat (5) begin
        @(negedge aclk);
        check("stall_rvalid_hold", 64'(rvalid), 64'd1);
        check("stall_rdata_hold", rdata, s_data);
        check("stall_rlast_hold", 64'(rlast), 64'(s_last));
        check("stall_rresp_hold", 64'(rresp), 64'(s_resp));
        check("stall_rid_hold", 64'(rid), 64'(s_id));
      end
      @(posedge aclk); #1 rready = 1'b1;
    end
    t = 0;
    while (r_q.size() != 0 && t < 100) begin @(posedge aclk); t++; end
    check("r_done", 64'(r_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, t;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
    check("rst_rid_rresp", 64'({rid, rresp}), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // INCR write 0x100, 4 beats of 1..4, then read back
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(4'h5, 32'h100, 8'd3, 3'd3, 2'b01, -1);
    axi_read(4'h6, 32'h100, 8'd3, 3'd3, 2'b01, -1);

    // WRAP read: 0x118, 0x100, 0x108, 0x110
    axi_read(4'h7, 32'h118, 8'd3, 3'd3, 2'b10, -1);

    // Partial strobes over a zeroed word
    wd[0] = 64'd0; ws[0] = 8'hFF;
    axi_write(4'h1, 32'h0, 8'd0, 3'd3, 2'b01, -1);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
    axi_write(4'h2, 32'h0, 8'd0, 3'd3, 2'b01, -1);
    axi_read(4'h3, 32'h0, 8'd0, 3'd3, 2'b01, -1);

    // Out-of-range write must not land anywhere (index would alias word 0)
    wd[0] = 64'h1234_5678_9ABC_DEF0; ws[0] = 8'hFF;
    axi_write(4'h4, 32'h2000, 8'd0, 3'd3, 2'b01, -1);
    axi_read(4'h4, 32'h0, 8'd0, 3'd3, 2'b01, -1);
    axi_read(4'h8, 32'h2000, 8'd0, 3'd3, 2'b01, -1);

    // Early wlast on beat 1 of a 4-beat burst
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
    axi_write(4'h9, 32'h140, 8'd3, 3'd3, 2'b01, 1);

    // rready low for 5 cycles after beat 1
    axi_read(4'hA, 32'h140, 8'd3, 3'd3, 2'b01, 1);

    // Reserved burst type behaves as INCR but answers SLVERR
    wd[0] = 64'hC0; wd[1] = 64'hC1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(4'hB, 32'h180, 8'd1, 3'd3, 2'b11, -1);
    axi_read(4'hB, 32'h180, 8'd1, 3'd3, 2'b01, -1);

    // Oversize read returns the aligned word with SLVERR; FIXED repeats one word
    axi_read(4'hC, 32'h100, 8'd0, 3'd4, 2'b01, -1);
    axi_read(4'hD, 32'h108, 8'd2, 3'd3, 2'b00, -1);

    // Reset while in W_DATA after one committed beat
    @(posedge aclk); #1;
    awid = 4'hE; awaddr = 32'h200; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    check("aw_accept_mid", 64'(awready), 64'd1);
    @(posedge aclk); #1 awvalid = 1'b0;
    wdata = 64'hDEAD_BEEF_0000_0200; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    model[32'h200 >> 3] = 64'hDEAD_BEEF_0000_0200;
    t = 0;
    @(negedge aclk);
    while (!wready && t < 50) begin @(negedge aclk); t++; end
    check("w_accept_mid", 64'(wready), 64'd1);
    @(posedge aclk); #1 wvalid = 1'b0;
    @(negedge aclk);
    check("wready_in_burst", 64'(wready), 64'd1);
    #2 areset = 1'b1;
    #1;
    check("midrst_awready", 64'(awready), 64'd0);
    check("midrst_wready", 64'(wready), 64'd0);
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    @(posedge aclk); @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("midrst_awready_after", 64'(awready), 64'd1);
    seen = 0;
    repeat (10) begin @(negedge aclk); if (bvalid) seen++; end
    check("midrst_no_bvalid", 64'(seen), 64'd0);
    $display("RST mid-burst: bvalid seen %0d times", seen);
    axi_read(4'hF, 32'h200, 8'd0, 3'd3, 2'b01, -1);
    axi_read(4'h6, 32'h100, 8'd3, 3'd3, 2'b01, -1);

    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 64, data width; STRB_W = DATA_W/8.
REQ-003 Parameter ID_W, default 4, transaction ID width.
REQ-004 Parameter MEM_WORDS, default 1024, memory depth in DATA_W words.
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high, as defined by the following ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
REQ-006 The AW channel SHALL have the following ports:
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write request fields.
- awvalid  in  1  /  awready  out  1.
REQ-007 The W channel SHALL have the following ports:
- wdata/wstrb/wlast/wvalid  in  DATA_W/STRB_W/1/1.
- wready  out  1.
REQ-008 The B channel SHALL have the following ports:
- bid/bresp/bvalid  out  ID_W/2/1.
- bready  in  1.
REQ-009 The AR channel SHALL have the following ports:
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2.
- arvalid  in  1  /  arready  out  1.
REQ-010 The R channel SHALL have the following ports:
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1.
- rready  in  1.
REQ-011 lock/cache/prot/qos/region/user signals SHALL NOT be ports; the integrator ties any buser/ruser to 0.

Function
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM R_IDLE, R_DATA; the two run independently, one outstanding transaction each.
REQ-013 awready SHALL be 1 only in W_IDLE, and on awvalid&awready the block SHALL latch the AW fields and enter W_DATA.
REQ-014 wready SHALL be 1 only in W_DATA; each wvalid&wready beat SHALL write bytes enabled by wstrb to the current word, then advance the address and the beat count.
REQ-015 The beat with count==awlen SHALL move the FSM to W_RESP with bvalid=1 next cycle, bid=latched awid; bvalid&bready SHALL return it to W_IDLE.
REQ-016 A wlast value not equal to (count==awlen) on any beat SHALL set bresp=SLVERR(2'b10); the burst still ends on the count.
REQ-017 arready SHALL be 1 only in R_IDLE; the AR handshake SHALL latch fields, and rvalid SHALL assert the next cycle with registered rdata of beat 0.
REQ-018 While rvalid&!rready, rid/rdata/rresp/rlast SHALL hold stable; each rvalid&rready SHALL present the next beat the following cycle (full throughput).
REQ-019 rlast SHALL be 1 on beat arlen only; its acceptance SHALL return the FSM to R_IDLE, and arready SHALL be 1 the following cycle.
REQ-020 Address advance SHALL follow the burst type:
- FIXED: address constant.
- INCR: next = (addr aligned to 2^size) + 2^size.
- WRAP: boundary B=(len+1)*2^size; on reaching (addr & ~(B-1))+B, wrap to addr & ~(B-1).
REQ-021 The following conditions SHALL produce SLVERR for the affected beat or burst:
- Word index = addr/STRB_W >= MEM_WORDS: write beat dropped, read data 0, SLVERR for that beat/burst.
- awsize/arsize > log2(STRB_W): SLVERR for the whole burst.
- burst 2'b11: treated as INCR, SLVERR.
- WRAP with len not in {1,3,7,15}: SLVERR.
REQ-022 In all other cases, response SHALL be OKAY(2'b00); EXOKAY SHALL never be returned.
REQ-023 Reads SHALL return the full aligned word regardless of size.
REQ-024 A same-word write and read fetch in the same cycle SHALL return old data (read-before-write).

Reset
REQ-025 While areset=1, awready, wready, bvalid, arready, rvalid and rlast SHALL be 0, bid/bresp/rid/rresp/rdata SHALL be 0, and both FSMs SHALL be idle.
REQ-026 Reset mid-burst SHALL abandon the burst without a response, and memory contents SHALL NOT be reset.
REQ-027 awready and arready SHALL be 1 on the first rising edge after areset falls.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- INCR write awaddr=0x100, awlen=3, size=3, wdata 1..4, all strobes -> bresp OKAY, bid echoed; INCR read same -> rdata 1,2,3,4, rlast on beat 3 only.
- WRAP read araddr=0x118, len=3, size=3 -> word addresses 0x118,0x100,0x108,0x110.
- Write wstrb=0x0F, wdata=0xFFFF_FFFF_FFFF_FFFF over 0 -> read returns 0x0000_0000_FFFF_FFFF.
- awaddr=MEM_WORDS*8 -> bresp SLVERR, memory unchanged; early wlast on beat 1 of len=3 -> SLVERR after 4 beats.
- rready held low 5 cycles mid-burst -> R outputs stable; areset pulse during W_DATA -> bvalid never asserts, awready=1 after release.
